// File: rtl/bamse_uart_tx_pkg.sv
// Shared definitions for the bamse UART transmitter: FSM states, status bit positions, default port IDs.
// BAMSE_UART_TX_PARITY_EN adds the PARITY state (8E1 framing).
package bamse_uart_tx_pkg;

   localparam int unsigned OPERAND_WIDTH = 8;

   localparam logic [OPERAND_WIDTH-1:0] TX_PORT_ID_DEF   = 8'h10;
   localparam logic [OPERAND_WIDTH-1:0] STAT_PORT_ID_DEF = 8'h11;

   localparam int unsigned TXST_FULL  = 0;
   localparam int unsigned TXST_EMPTY = 1;
   localparam int unsigned TXST_BUSY  = 2;
   localparam int unsigned TXST_OVF   = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef BAMSE_UART_TX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP
   } tx_state_t;

   function automatic logic [OPERAND_WIDTH-1:0] status_byte(input logic full, input logic empty,
                                                            input logic busy, input logic ovf);
      logic [OPERAND_WIDTH-1:0] s;
      s             = '0;
      s[TXST_FULL]  = full;
      s[TXST_EMPTY] = empty;
      s[TXST_BUSY]  = busy;
      s[TXST_OVF]   = ovf;
      return s;
   endfunction

endpackage

// File: rtl/bamse_fifo.sv
// Synchronous FIFO with combinational head read; shared by the UART transmitter and a future receiver.
module bamse_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] rd_data
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A push while full is only taken when the head leaves on the same edge.
   always_comb begin
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   always_comb begin
      empty   = (wr_ptr == rd_ptr);
      full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      rd_data = mem[rd_ptr[AW-1:0]];
   end

endmodule

// File: rtl/bamse_uart_tx.sv
// Buffered UART transmitter on the PacoBlaze port bus with status port and drain interrupt.
// BAMSE_UART_TX_PARITY_EN selects 8E1 framing; default is 8N1.
module bamse_uart_tx
   import bamse_uart_tx_pkg::*;
#(
   parameter int unsigned                 CLK_DIV      = 434,
   parameter int unsigned                 FIFO_DEPTH   = 8,
   parameter logic [OPERAND_WIDTH-1:0]    TX_PORT_ID   = TX_PORT_ID_DEF,
   parameter logic [OPERAND_WIDTH-1:0]    STAT_PORT_ID = STAT_PORT_ID_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [OPERAND_WIDTH-1:0] port_id,
   input  logic [OPERAND_WIDTH-1:0] port_in,
   input  logic                     wen,
   input  logic                     ren,
   output logic [OPERAND_WIDTH-1:0] port_out,
   output logic                     txd,
   output logic                     tx_busy,
   output logic                     tx_irq
);

   localparam int unsigned      TW         = $clog2(CLK_DIV);
   localparam logic [TW-1:0]    TIMER_LOAD = TW'(CLK_DIV - 1);

   tx_state_t                  state, state_next;
   logic [TW-1:0]              timer;
   logic                       timer_zero;
   logic [2:0]                 bit_cnt;
   logic [OPERAND_WIDTH-1:0]   shreg;
   logic                       overflow;
   logic                       tx_wr, stat_sel, stat_rd;
   logic                       fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [OPERAND_WIDTH-1:0]   fifo_rd_data;
`ifdef BAMSE_UART_TX_PARITY_EN
   logic                       parity_bit;
`endif

   always_comb begin
      tx_wr      = wen && (port_id == TX_PORT_ID);
      stat_sel   = (port_id == STAT_PORT_ID);
      stat_rd    = ren && stat_sel;
      fifo_push  = tx_wr;
      timer_zero = (timer == '0);
   end

   bamse_fifo #(.WIDTH(OPERAND_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .wr_data (port_in),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .rd_data (fifo_rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Popping from STOP straight into START keeps queued frames back-to-back.
   always_comb begin
      state_next = state;
      fifo_pop   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               state_next = ST_START;
               fifo_pop   = 1'b1;
            end
         end
         ST_START: if (timer_zero) state_next = ST_DATA;
         ST_DATA: begin
            if (timer_zero && bit_cnt == 3'd7) begin
`ifdef BAMSE_UART_TX_PARITY_EN
               state_next = ST_PARITY;
`else
               state_next = ST_STOP;
`endif
            end
         end
`ifdef BAMSE_UART_TX_PARITY_EN
         ST_PARITY: if (timer_zero) state_next = ST_STOP;
`endif
         ST_STOP: begin
            if (timer_zero) begin
               if (!fifo_empty) begin
                  state_next = ST_START;
                  fifo_pop   = 1'b1;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      txd = 1'b1;
      case (state)
         ST_START:  txd = 1'b0;
         ST_DATA:   txd = shreg[0];
`ifdef BAMSE_UART_TX_PARITY_EN
         ST_PARITY: txd = parity_bit;
`endif
         default:   txd = 1'b1;
      endcase
      tx_busy = (state != ST_IDLE) || !fifo_empty;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         timer    <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         overflow <= 1'b0;
         tx_irq   <= 1'b0;
         port_out <= '0;
`ifdef BAMSE_UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         tx_irq <= (state == ST_STOP) && timer_zero && fifo_empty;

         if (state_next != state || (state == ST_DATA && timer_zero)) timer <= TIMER_LOAD;
         else if (!timer_zero)                                      timer <= timer - 1'b1;

         if (fifo_pop) begin
            shreg   <= fifo_rd_data;
            bit_cnt <= '0;
`ifdef BAMSE_UART_TX_PARITY_EN
            parity_bit <= ^fifo_rd_data;
`endif
         end else if (state == ST_DATA && timer_zero) begin
            shreg <= {1'b0, shreg[OPERAND_WIDTH-1:1]};
            if (bit_cnt != 3'd7) bit_cnt <= bit_cnt + 1'b1;
         end

         // A drop on the same edge as a status read leaves the flag set.
         if (tx_wr && fifo_full && !fifo_pop) overflow <= 1'b1;
         else if (stat_rd)                    overflow <= 1'b0;

         port_out <= stat_sel ? status_byte(fifo_full, fifo_empty, tx_busy, overflow) : '0;
      end
   end

endmodule

// File: tb/tb_bamse_uart_tx.sv
// Self-checking bench for bamse_uart_tx: frame-level reference model compared every cycle plus literal checks.
module tb_bamse_uart_tx;

   localparam int unsigned CLK_DIV = 4;
   localparam int unsigned DEPTH   = 8;
`ifdef BAMSE_UART_TX_PARITY_EN
   localparam int unsigned NBITS = 11;
`else
   localparam int unsigned NBITS = 10;
`endif
   localparam int unsigned FRAME = NBITS * CLK_DIV;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wen = 1'b0;
   logic       ren = 1'b0;
   logic [7:0] port_id = '0;
   logic [7:0] port_in = '0;
   logic [7:0] port_out;
   logic       txd, tx_busy, tx_irq;

   always #5 clk = ~clk;

   bamse_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .TX_PORT_ID(8'h10), .STAT_PORT_ID(8'h11)) dut (
      .clk      (clk),
      .rst      (rst),
      .port_id  (port_id),
      .port_in  (port_in),
      .wen      (wen),
      .ren      (ren),
      .port_out (port_out),
      .txd      (txd),
      .tx_busy  (tx_busy),
      .tx_irq   (tx_irq)
   );

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of bytes plus a frame-position counter.
   logic [7:0] q[$];
   bit         m_active;
   int         m_k;
   logic [7:0] m_data;
   bit         m_ovf;
   logic [7:0] m_port_out;
   bit         m_irq;

   function automatic logic frame_bit(input logic [7:0] d, input int k);
      int b;
      b = k / CLK_DIV;
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
`ifdef BAMSE_UART_TX_PARITY_EN
      if (b == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         m_active   = 1'b0;
         m_k        = 0;
         m_ovf      = 1'b0;
         m_port_out = '0;
         m_irq      = 1'b0;
      end else begin : model_step
         int pre;
         bit pre_busy;
         bit will_pop;
         pre      = q.size();
         pre_busy = m_active || (pre != 0);
         will_pop = 1'b0;
         m_port_out = (port_id == 8'h11) ?
                      {4'b0, m_ovf, pre_busy, (pre == 0), (pre == int'(DEPTH))} : 8'h00;
         m_irq = 1'b0;
         if (m_active) begin
            m_k++;
            if (m_k == int'(FRAME)) begin
               m_active = 1'b0;
               if (pre == 0) m_irq = 1'b1;
            end
         end
         if (!m_active && pre != 0) begin
            will_pop = 1'b1;
            m_data   = q.pop_front();
            m_active = 1'b1;
            m_k      = 0;
         end
         if (ren && port_id == 8'h11) m_ovf = 1'b0;
         if (wen && port_id == 8'h10) begin
            if (pre < int'(DEPTH) || will_pop) q.push_back(port_in);
            else m_ovf = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("txd", txd, m_active ? frame_bit(m_data, m_k) : 1'b1);
         check("tx_busy", tx_busy, m_active || q.size() != 0);
         check("tx_irq", tx_irq, m_irq);
         check("port_out", port_out, m_port_out);
      end
   end

   task automatic wr(input logic [7:0] id, input logic [7:0] d);
      port_id = id;
      port_in = d;
      wen     = 1'b1;
      @(negedge clk);
      wen     = 1'b0;
      port_id = '0;
      port_in = '0;
   endtask

   task automatic rd_status(output logic [7:0] v);
      port_id = 8'h11;
      @(negedge clk);
      ren = 1'b1;
      @(negedge clk);
      v       = port_out;
      ren     = 1'b0;
      port_id = '0;
   endtask

   task automatic run_to_irq(input int maxc, output int n);
      n = 0;
      while (tx_irq !== 1'b1 && n < maxc) begin
         @(negedge clk);
         n++;
      end
      check("irq_timeout", tx_irq, 1'b1);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  v;
      logic [10:0] ev;
      time         t0;
      int          n, nirq;

      // 1: reset state
      @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_txd", txd, 1'b1);
      check("rst_busy", tx_busy, 1'b0);
      check("rst_irq", tx_irq, 1'b0);
      port_id = 8'h11;
      @(negedge clk);
      check("stat_reset", port_out, 8'h02);
      port_id = '0;
      @(negedge clk);

      // 2: single frame 0x55
`ifdef BAMSE_UART_TX_PARITY_EN
      ev = {1'b1, 1'b0, 8'h55, 1'b0};
`else
      ev = {1'b0, 1'b1, 8'h55, 1'b0};
`endif
      wr(8'h10, 8'h55);
      check("lat_e0_txd", txd, 1'b1);
      @(negedge clk);
      check("lat_e1_txd", txd, 1'b0);
      for (int idx = 1; idx <= int'(FRAME) + 1; idx++) begin
         @(negedge clk);
         if (idx % CLK_DIV == 2 && idx / CLK_DIV < int'(NBITS))
            check("bit55", txd, ev[idx / CLK_DIV]);
         if (idx == int'(FRAME) - 1) check("irq_early", tx_irq, 1'b0);
         if (idx == int'(FRAME)) begin
            check("irq_at_frame_end", tx_irq, 1'b1);
            check("busy_drop", tx_busy, 1'b0);
         end
         if (idx == int'(FRAME) + 1) check("irq_one_cycle", tx_irq, 1'b0);
      end
      repeat (3) @(negedge clk);

      // 3: overflow and back-to-back frames
      t0 = $time;
      for (int i = 0; i < 10; i++) begin
         wr(8'h10, 8'h30 + 8'(i));
         if (i == 0) t0 = $time;
         @(negedge clk);
      end
      rd_status(v);
      check("stat_ovf", v, 8'h0D);
      rd_status(v);
      check("stat_ovf_cleared", v, 8'h05);
      run_to_irq(9 * FRAME + 50, n);
      check("burst_len", int'(($time - t0) / 10), 1 + 9 * FRAME);
      nirq = 0;
      for (int i = 0; i < int'(2 * FRAME); i++) begin
         @(negedge clk);
         if (tx_irq) nirq++;
      end
      check("burst_single_irq", nirq, 0);

      // 4: frame length with 0x07
      wr(8'h10, 8'h07);
      t0 = $time;
      run_to_irq(FRAME + 20, n);
`ifdef BAMSE_UART_TX_PARITY_EN
      check("len_07", int'(($time - t0) / 10), 45);
`else
      check("len_07", int'(($time - t0) / 10), 41);
`endif
      repeat (3) @(negedge clk);

      // 5: reset during data bit 3 with bytes queued
      for (int i = 0; i < 3; i++) begin
         wr(8'h10, 8'hA5 ^ 8'(i));
         @(negedge clk);
      end
      repeat (13) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_txd", txd, 1'b1);
      check("rst_mid_busy", tx_busy, 1'b0);
      nirq = 0;
      for (int i = 0; i < int'(3 * FRAME); i++) begin
         @(negedge clk);
         if (tx_irq) nirq++;
         if (i == 0 || i == int'(FRAME)) check("rst_mid_idle", txd, 1'b1);
      end
      check("rst_mid_no_irq", nirq, 0);
      rd_status(v);
      check("rst_mid_stat", v, 8'h02);

      // 6: foreign port
      wr(8'h12, 8'hAA);
      port_id = 8'h12;
      ren     = 1'b1;
      @(negedge clk);
      check("foreign_port_out", port_out, 8'h00);
      ren     = 1'b0;
      port_id = '0;
      repeat (int'(FRAME)) @(negedge clk);
      check("foreign_busy", tx_busy, 1'b0);
      check("foreign_txd", txd, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
